// File: rtl/outer_loop_ctrl_pkg.sv
// Shared constants and state encoding for the outer-loop sequencer of the
// 3072-bit digit-serial multiplier.
package outer_loop_pkg;

    localparam int SIZE    = 3072;
    localparam int RADIX   = 78;
    localparam int DIGITS  = (SIZE + RADIX - 1) / RADIX;
    localparam int IDX_W   = $clog2(DIGITS);
    localparam int TIMEOUT = 16;
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACC,
        ST_DONE
    } state_e;

endpackage

// File: rtl/outer_loop_ctrl_digit_shifter.sv
// Loadable right-shift register holding operand B. The low RADIX bits are
// the current digit; each shift drops one digit and zero-fills from the top.
// The register is padded to DIGITS*RADIX bits so the last digit's unused
// upper bits read as zero.
module digit_shifter
    import outer_loop_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [SIZE-1:0]  load_data,
    output logic [RADIX-1:0] digit
);

    localparam int REG_W = DIGITS * RADIX;

    logic [REG_W-1:0] sr_q;
    logic [REG_W-1:0] sr_d;

    // Next value: load wins over shift; otherwise hold.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = {{(REG_W - SIZE){1'b0}}, load_data};
        end else if (shift) begin
            sr_d = {{RADIX{1'b0}}, sr_q[REG_W-1:RADIX]};
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign digit = sr_q[RADIX-1:0];

endmodule

// File: rtl/outer_loop_ctrl.sv
// Outer-loop sequencer: feeds operand B digit by digit to the inner loop and
// hands each result to the accumulator with its digit index.
// Optional watchdog in WAIT enabled by defining OUTER_CTRL_TIMEOUT_EN.
module outer_loop_ctrl
    import outer_loop_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [SIZE-1:0]  b,
    output logic             inner_en,
    output logic [RADIX-1:0] inner_bi,
    input  logic             inner_done,
    output logic             acc_en,
    input  logic             acc_ready,
    output logic [IDX_W-1:0] acc_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             load;
    logic             shift;

`ifdef OUTER_CTRL_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;
    logic             err_q;
    logic             err_d;
`endif

    digit_shifter u_digit_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_data (b),
        .digit     (inner_bi)
    );

    // Next-state, digit index, shifter control and watchdog; abort overrides all.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        shift   = 1'b0;
`ifdef OUTER_CTRL_TIMEOUT_EN
        tmo_d   = '0;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = ST_ISSUE;
`ifdef OUTER_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (inner_done) begin
                    state_d = ST_ACC;
`ifdef OUTER_CTRL_TIMEOUT_EN
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d   = tmo_q + 1'b1;
`endif
                end
            end
            ST_ACC: begin
                if (acc_ready) begin
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        shift   = 1'b1;
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            load    = 1'b0;
            shift   = 1'b0;
`ifdef OUTER_CTRL_TIMEOUT_EN
            tmo_d   = '0;
            err_d   = err_q;
`endif
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

`ifdef OUTER_CTRL_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign inner_en = (state_q == ST_ISSUE) && !abort;
    assign acc_en   = (state_q == ST_ACC)   && !abort;
    assign done     = (state_q == ST_DONE)  && !abort;
    assign busy     = (state_q != ST_IDLE);
    assign acc_idx  = idx_q;

endmodule

// File: tb/tb_outer_loop_ctrl.sv
// Self-checking bench for outer_loop_ctrl: vector table of full passes,
// randomized passes against a timeline model, and hand-written corner cases.
module tb_outer_loop_ctrl;
    import outer_loop_pkg::*;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [SIZE-1:0]  b;
    logic             inner_en;
    logic [RADIX-1:0] inner_bi;
    logic             inner_done;
    logic             acc_en;
    logic             acc_ready;
    logic [IDX_W-1:0] acc_idx;
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;

    outer_loop_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .b          (b),
        .inner_en   (inner_en),
        .inner_bi   (inner_bi),
        .inner_done (inner_done),
        .acc_en     (acc_en),
        .acc_ready  (acc_ready),
        .acc_idx    (acc_idx),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE-1:0]  b;
        int               stall_idx;
        int               stall_len;
        int               abort_idx;
        int               exp_done;
        int               exp_cnt;
        logic [RADIX-1:0] exp_first;
        logic [RADIX-1:0] exp_last;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    // One multiplication pass. Cycle 0 is the cycle start is presented.
    // Expected timing comes from a digit timeline: digit k is issued six
    // cycles before its accumulator window opens, and the next window opens
    // seven cycles after an acceptance.
    task automatic run_pass(input logic [SIZE-1:0] bv, input int stall_idx, input int stall_len,
                            input int abort_idx, input bit rnd,
                            output int done_cyc, output int cnt,
                            output logic [RADIX-1:0] d_first, output logic [RADIX-1:0] d_last);
        logic [DIGITS*RADIX-1:0] ext;
        logic [RADIX-1:0]        want_digit;
        int  k, acc_from, due, stall_left, exp_done_c, abort_c;
        bit  aborted, abort_now, exp_acc, exp_issue, exp_busy, exp_done, finished, noise_ok;
        ext        = '0;
        ext[SIZE-1:0] = bv;
        k          = 0;
        acc_from   = 7;
        due        = -100;
        stall_left = stall_len;
        exp_done_c = -1;
        abort_c    = -1;
        aborted    = 1'b0;
        finished   = 1'b0;
        done_cyc   = -1;
        cnt        = 0;
        d_first    = '0;
        d_last     = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            noise_ok  = !aborted && (exp_done_c < 0 || c <= exp_done_c);
            start     = (c == 0) || (rnd && c > 0 && noise_ok && $urandom_range(0, 15) == 0);
            b         = (c == 0) ? bv : ~bv;
            abort_now = !aborted && k == abort_idx && c == acc_from - 3;
            abort     = abort_now;
            inner_done = (c == due);
            exp_acc   = !aborted && k < DIGITS && c >= acc_from;
            exp_issue = !aborted && k < DIGITS && c == acc_from - 6;
            exp_done  = !aborted && c == exp_done_c;
            exp_busy  = (c != 0) && !aborted && (exp_done_c < 0 || c <= exp_done_c);
            if (exp_acc && k == stall_idx && stall_left > 0) begin
                acc_ready = 1'b0;
                stall_left--;
            end else if (rnd) begin
                acc_ready = ($urandom_range(0, 3) != 0);
            end else begin
                acc_ready = 1'b1;
            end
            want_digit = ext[k*RADIX +: RADIX];
            #1;
            chk($sformatf("inner_en@%0d", c), 128'(inner_en), 128'(exp_issue));
            chk($sformatf("acc_en@%0d", c), 128'(acc_en), 128'(exp_acc));
            chk($sformatf("done@%0d", c), 128'(done), 128'(exp_done));
            chk($sformatf("busy@%0d", c), 128'(busy), 128'(exp_busy));
            if (exp_issue) begin
                chk($sformatf("inner_bi_issue@%0d", c), 128'(inner_bi), 128'(want_digit));
            end
            if (exp_acc) begin
                chk($sformatf("acc_idx@%0d", c), 128'(acc_idx), 128'(k));
                chk($sformatf("inner_bi_acc@%0d", c), 128'(inner_bi), 128'(want_digit));
            end
            if (inner_en) due = c + 5;
            if (done && done_cyc < 0) done_cyc = c;
            if (exp_acc && acc_ready) begin
                if (k == 0) d_first = inner_bi;
                d_last = inner_bi;
                cnt++;
                if (k == DIGITS - 1) exp_done_c = c + 1;
                k++;
                acc_from = c + 7;
            end
            if (abort_now) begin
                aborted = 1'b1;
                abort_c = c;
            end
            if ((exp_done_c >= 0 && c >= exp_done_c + 3) || (aborted && c >= abort_c + 3)) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) chk("pass_cycle_budget", 128'(finished), 128'(1));
        @(negedge clk);
        start      = 1'b0;
        abort      = 1'b0;
        inner_done = 1'b0;
        acc_ready  = 1'b1;
    endtask

    vec_t             vecs[6];
    int               dc, cn;
    logic [RADIX-1:0] df, dl;
    logic [SIZE-1:0]  rb;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; b = '0;
        inner_done = 1'b0; acc_ready = 1'b1;

        // Table of directed passes.
        vecs[0] = '{b: SIZE'(1), stall_idx: -1, stall_len: 0, abort_idx: -1, exp_done: 281,
                    exp_cnt: 40, exp_first: RADIX'(1), exp_last: '0};
        vecs[1] = '{b: '1, stall_idx: -1, stall_len: 0, abort_idx: -1, exp_done: 281,
                    exp_cnt: 40, exp_first: '1, exp_last: 78'h3FFF_FFFF};
        vecs[2] = '{b: SIZE'(1), stall_idx: 5, stall_len: 3, abort_idx: -1, exp_done: 284,
                    exp_cnt: 40, exp_first: RADIX'(1), exp_last: '0};
        vecs[3] = '{b: SIZE'(1), stall_idx: -1, stall_len: 0, abort_idx: 10, exp_done: -1,
                    exp_cnt: 10, exp_first: RADIX'(1), exp_last: '0};
        vecs[4] = '{b: SIZE'(1) << (SIZE - 1), stall_idx: -1, stall_len: 0, abort_idx: -1,
                    exp_done: 281, exp_cnt: 40, exp_first: '0, exp_last: 78'h2000_0000};
        vecs[5] = '{b: SIZE'(1) << (SIZE - 1), stall_idx: 39, stall_len: 2, abort_idx: -1,
                    exp_done: 283, exp_cnt: 40, exp_first: '0, exp_last: 78'h2000_0000};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_inner_en", 128'(inner_en), 128'(0));
        chk("rst_acc_en", 128'(acc_en), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_acc_idx", 128'(acc_idx), 128'(0));
        chk("rst_inner_bi", 128'(inner_bi), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_pass(vecs[i].b, vecs[i].stall_idx, vecs[i].stall_len, vecs[i].abort_idx, 1'b0,
                     dc, cn, df, dl);
            chk_int($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
            chk_int($sformatf("vec%0d_digit_count", i), cn, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_first_digit", i), 128'(df), 128'(vecs[i].exp_first));
            chk($sformatf("vec%0d_last_digit", i), 128'(dl), 128'(vecs[i].exp_last));
            #1;
            chk($sformatf("vec%0d_idle_busy", i), 128'(busy), 128'(0));
            chk($sformatf("vec%0d_err", i), 128'(err), 128'(0));
        end

        // Randomized passes: random operand, random stalls, stray starts.
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < SIZE / 32; w++) rb[w*32 +: 32] = $urandom();
            run_pass(rb, -1, 0, -1, 1'b1, dc, cn, df, dl);
            chk_int($sformatf("rnd%0d_digit_count", i), cn, DIGITS);
            chk($sformatf("rnd%0d_first_digit", i), 128'(df), 128'(rb[RADIX-1:0]));
            chk($sformatf("rnd%0d_last_digit", i), 128'(dl), 128'({48'd0, rb[SIZE-1 -: 30]}));
        end

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; b = '1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("abort_start_busy%0d", i), 128'(busy), 128'(0));
            chk($sformatf("abort_start_inner_en%0d", i), 128'(inner_en), 128'(0));
            @(negedge clk);
        end

        // Asynchronous reset mid-pass takes effect without a clock edge.
        start = 1'b1; b = SIZE'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_async_busy", 128'(busy), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 128'(busy), 128'(0));
        chk("async_rst_inner_bi", 128'(inner_bi), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef OUTER_CTRL_TIMEOUT_EN
        // Watchdog: inner loop never answers.
        inner_done = 1'b0;
        start = 1'b1; b = SIZE'(1);
        for (int c = 0; c < 20; c++) begin
            if (c == 1) start = 1'b0;
            #1;
            chk($sformatf("wd_done@%0d", c), 128'(done), 128'(0));
            if (c == 17) begin
                chk("wd_busy_last_wait", 128'(busy), 128'(1));
                chk("wd_err_before", 128'(err), 128'(0));
            end
            if (c == 18) begin
                chk("wd_busy_after", 128'(busy), 128'(0));
                chk("wd_err_after", 128'(err), 128'(1));
            end
            @(negedge clk);
        end
        chk("wd_err_sticky", 128'(err), 128'(1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("wd_err_cleared", 128'(err), 128'(0));
        chk("wd_restart_busy", 128'(busy), 128'(1));
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
